// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin sharing of one combinational FP32 adder among N_REQ requesters
module fp_add_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    input  logic [31:0]           add_o,
    output logic                  res_valid,
    output logic [31:0]           res_data,
    output logic [IDW-1:0]        res_id,
    input  logic                  res_ready,
    output logic [CNTW-1:0]       op_count
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] cand_idx;
    logic           gnt_found;
    logic           free;
    logic           grant;

    assign free = !res_valid || res_ready;

    // Search starts just past the last winner so every active requester is reached within N_REQ grants.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_idx = IDW'((int'(ptr) + k) % N_REQ);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    assign grant = gnt_found && free && !rst;

    always_comb begin
        req_ready = '0;
        add_a     = 32'h0;
        add_b     = 32'h0;
        if (grant) begin
            req_ready[gnt_idx] = 1'b1;
            add_a              = req_a[int'(gnt_idx)*32 +: 32];
            add_b              = req_b[int'(gnt_idx)*32 +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= 32'h0;
            res_id    <= '0;
            op_count  <= '0;
            ptr       <= IDW'(N_REQ - 1);
        end else if (grant) begin
            res_valid <= 1'b1;
            res_data  <= add_o;
            res_id    <= gnt_idx;
            ptr       <= gnt_idx;
            op_count  <= op_count + 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - directed self-checking bench for fp_add_arbiter
module tb_fp_add_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic [31:0]  add_a, add_b, add_o;
    logic         res_valid;
    logic [31:0]  res_data;
    logic [1:0]   res_id;
    logic         res_ready;
    logic [15:0]  op_count;

    logic [3:0]   w_req_ready;
    logic [31:0]  w_add_a, w_add_b, w_add_o;
    logic         w_res_valid;
    logic [31:0]  w_res_data;
    logic [1:0]   w_res_id;
    logic [3:0]   w_op_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Stand-in adder: exact IEEE sums for the directed float cases, integer sum as a unique tag otherwise.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h40400000 && b == 32'hC0400000) return 32'h00000000;
        return a + b;
    endfunction

    always_comb add_o   = fp_model(add_a, add_b);
    always_comb w_add_o = fp_model(w_add_a, w_add_b);

    fp_add_arbiter #(.N_REQ(4), .IDW(2), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_o(add_o),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ready(res_ready), .op_count(op_count)
    );

    fp_add_arbiter #(.N_REQ(4), .IDW(2), .CNTW(4)) dut_w (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(w_req_ready), .add_a(w_add_a), .add_b(w_add_b), .add_o(w_add_o),
        .res_valid(w_res_valid), .res_data(w_res_data), .res_id(w_res_id),
        .res_ready(res_ready), .op_count(w_op_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; res_ready = 1'b1;
        req_a = '0; req_b = '0;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        n_cmp++; if (add_a !== 32'h0) begin n_err++; $display("FAIL reset_add_a got %h want 0", add_a); end
        step();
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        n_cmp++; if (res_data !== 32'h0) begin n_err++; $display("FAIL reset_res_data got %h want 0", res_data); end
        n_cmp++; if (res_id !== 2'd0) begin n_err++; $display("FAIL reset_res_id got %0d want 0", res_id); end
        n_cmp++; if (op_count !== 16'd0) begin n_err++; $display("FAIL reset_op_count got %0d want 0", op_count); end
        rst = 1'b0; req_valid = 4'h0;
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_a[64 +: 32] = 32'h3F800000;
        req_b[64 +: 32] = 32'h40000000;
        res_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_req_ready got %b want 0100", req_ready); end
        n_cmp++; if (add_b !== 32'h40000000) begin n_err++; $display("FAIL single_add_b got %h want 40000000", add_b); end
        step();
        req_valid = 4'b0000;
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL single_res_valid got %b want 1", res_valid); end
        n_cmp++; if (res_data !== 32'h40400000) begin n_err++; $display("FAIL single_res_data got %h want 40400000", res_data); end
        n_cmp++; if (res_id !== 2'd2) begin n_err++; $display("FAIL single_res_id got %0d want 2", res_id); end
        n_cmp++; if (op_count !== 16'd1) begin n_err++; $display("FAIL single_op_count got %0d want 1", op_count); end
        #1;
        n_cmp++; if (add_a !== 32'h0) begin n_err++; $display("FAIL idle_add_a got %h want 0", add_a); end
        step();
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", res_valid); end
        n_cmp++; if (res_data !== 32'h40400000) begin n_err++; $display("FAIL single_hold_data got %h want 40400000", res_data); end
    endtask

    task automatic test_contention();
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'h100 * (i + 1);
            req_b[i*32 +: 32] = i;
        end
        req_valid = 4'hF; res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++; if (req_ready !== (4'b0001 << (k % 4))) begin n_err++; $display("FAIL cont_grant[%0d] got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
            step();
            n_cmp++; if (res_id !== 2'(k % 4)) begin n_err++; $display("FAIL cont_res_id[%0d] got %0d want %0d", k, res_id, k % 4); end
            n_cmp++; if (res_data !== 32'h100 * ((k % 4) + 1) + (k % 4)) begin n_err++; $display("FAIL cont_res_data[%0d] got %h want %h", k, res_data, 32'h100 * ((k % 4) + 1) + (k % 4)); end
        end
        n_cmp++; if (op_count !== 16'd8) begin n_err++; $display("FAIL cont_op_count got %0d want 8", op_count); end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_req_ready[%0d] got %b want 0000", k, req_ready); end
            step();
            n_cmp++; if (res_data !== 32'h403 || res_id !== 2'd3 || res_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d] got %h/%0d/%b want 403/3/1", k, res_data, res_id, res_valid); end
        end
        res_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_release_grant got %b want 0001", req_ready); end
        step();
        n_cmp++; if (res_id !== 2'd0 || res_data !== 32'h100) begin n_err++; $display("FAIL bp_release_res got %0d/%h want 0/100", res_id, res_data); end
        n_cmp++; if (op_count !== 16'd9) begin n_err++; $display("FAIL bp_op_count got %0d want 9", op_count); end
    endtask

    task automatic test_cancel();
        req_valid = 4'b0010;
        req_a[32 +: 32] = 32'h40400000;
        req_b[32 +: 32] = 32'hC0400000;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL cancel_grant got %b want 0010", req_ready); end
        step();
        n_cmp++; if (res_data !== 32'h00000000) begin n_err++; $display("FAIL cancel_res_data got %h want 00000000", res_data); end
        n_cmp++; if (res_id !== 2'd1) begin n_err++; $display("FAIL cancel_res_id got %0d want 1", res_id); end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0000; res_ready = 1'b0;
        step();
        req_valid = 4'b1010; rst = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_req_ready_in_rst got %b want 0000", req_ready); end
        step();
        rst = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL mid_res_valid got %b want 0", res_valid); end
        n_cmp++; if (res_data !== 32'h0) begin n_err++; $display("FAIL mid_res_data got %h want 0", res_data); end
        n_cmp++; if (op_count !== 16'd0) begin n_err++; $display("FAIL mid_op_count got %0d want 0", op_count); end
        res_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_first_grant got %b want 0010", req_ready); end
        step();
        n_cmp++; if (res_id !== 2'd1) begin n_err++; $display("FAIL mid_first_id got %0d want 1", res_id); end
    endtask

    task automatic test_wrap();
        req_valid = 4'b0000;
        pulse_reset();
        req_valid = 4'b0001; res_ready = 1'b1;
        for (int k = 0; k < 17; k++) step();
        req_valid = 4'b0000;
        n_cmp++; if (w_op_count !== 4'd1) begin n_err++; $display("FAIL wrap_op_count got %0d want 1", w_op_count); end
        n_cmp++; if (op_count !== 16'd17) begin n_err++; $display("FAIL wide_op_count got %0d want 17", op_count); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_cancel();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin scheduler that shares one combinational FP32 adder among `N_REQ` requesters in the accelerator's accumulation datapath. Each requester presents an operand pair under a valid/ready handshake. The arbiter grants at most one pair per cycle and steers it onto the shared adder's inputs. It captures the adder's sum in a single output register, which is drained under its own valid/ready handshake and tagged with the requester index.

## Interface

Parameters:
- `N_REQ`, 4, number of requesters; range 2..16.
- `IDW`, 2, width of `res_id`; must equal clog2(`N_REQ`).
- `CNTW`, 16, width of the accepted-operation counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `N_REQ`  bit i: requester i presents an operand pair.
- `req_a`  in  32*`N_REQ`  operand A of requester i in bits [32i+31:32i], IEEE-754 single.
- `req_b`  in  32*`N_REQ`  operand B of requester i, same packing.
- `req_ready`  out  `N_REQ`  one-hot grant; the pair is accepted when `req_valid[i] & req_ready[i]`.
- `add_a`  out  32  operand A to the shared adder.
- `add_b`  out  32  operand B to the shared adder.
- `add_o`  in  32  sum returned combinationally by the shared adder in the same cycle.
- `res_valid`  out  1  the output register holds an undelivered sum.
- `res_data`  out  32  registered sum.
- `res_id`  out  `IDW`  index of the requester that produced `res_data`.
- `res_ready`  in  1  consumer accepts the result when `res_valid & res_ready`.
- `op_count`  out  `CNTW`  number of accepted operand pairs; wraps modulo 2^`CNTW`.

## Operation

- **Slot free.** `free = !res_valid | res_ready`. Grants are issued only when `free` is high and `rst` is low.
- **Grant selection.** Round-robin search starts at `ptr+1` (mod `N_REQ`) and selects the first i with `req_valid[i]`. That requester's `req_ready[i]` goes high combinationally; all other `req_ready` bits are 0.
- **No combinational loops.** `req_ready` may depend on `req_valid`. Requesters must not derive `req_valid` from `req_ready`.
- **Adder steering.** `add_a`/`add_b` carry the granted requester's operands. When no grant is issued, they are driven to 32'h0.
- **On grant:**
  - `res_data <= add_o`, `res_id <= i`, `res_valid <= 1`.
  - `ptr <= i`.
  - `op_count <= op_count + 1`.
- **No grant, `res_valid & res_ready`:** `res_valid <= 0`. `res_data` and `res_id` hold their values.
- **No grant, otherwise:** all state holds.
- **Stable output.** While `res_valid & !res_ready`, `res_data` and `res_id` are stable and every `req_ready` bit is 0.
- **Arithmetic.** The block performs none; sums are exactly `add_o`. Zero, sign and normalisation handling belong to the adder.
- **Reset values:**
  - `res_valid=0`, `res_data=32'h0`, `res_id=0`, `op_count=0`.
  - `ptr=N_REQ-1`, so requester 0 has first priority.
  - `req_ready=0`, `add_a=add_b=0` while `rst` is high.
- **Reset mid-operation.** A pending undelivered result is discarded. An operand pair presented in the reset cycle is not accepted.

## Timing

- **Latency.** One cycle from handshake acceptance (edge k) to `res_valid=1` with the sum, visible after edge k.
- **Throughput.** One operation per cycle while `res_ready` is held high. Drain and new grant occur in the same cycle.
- **Fairness.** A requester holding `req_valid` high is granted within `N_REQ` grants.
- **Counter wrap.** `op_count` wraps from 2^`CNTW`-1 to 0 with no flag.
- **Critical path.** Arbitration, then operand mux, then the external adder, then `res_data` capture, all in one cycle. The adder must close timing inside this path.

## Test plan

Benches connect the team's FP32 adder between `add_a`/`add_b` and `add_o`.

- **Single request.** Req 2 presents 0x3F800000 + 0x40000000 (1.0+2.0) after reset, `res_ready=1` → `req_ready=4'b0100` that cycle. Next cycle: `res_valid=1`, `res_data=0x40400000`, `res_id=2`, `op_count=1`.
- **Full contention.** All 4 `req_valid` held high, `res_ready=1` → grants 0,1,2,3,0,1 on consecutive cycles, `res_id` follows one cycle later, no idle cycles. 8 cycles give `op_count=8`.
- **Backpressure.** `res_ready=0` with `res_valid=1` for 5 cycles → `req_ready=0`, `res_data`/`res_id` unchanged. When `res_ready` rises, the old result drains and the next requester is granted in the same cycle, with no bubble.
- **Cancellation and sign.** Req 1 presents 0x40400000 + 0xC0400000 (3.0 + -3.0) → `res_data=0x00000000`, `res_id=1`.
- **Reset mid-operation.** `res_valid=1` with `res_ready=0`, then `rst` asserted for one cycle → after the edge `res_valid=0`, `res_data=0`, `op_count=0`, `req_ready=0` during `rst`. The first grant after reset goes to the lowest valid index.
- **Counter wrap.** With `CNTW=4`, 17 accepted operations → `op_count=1`.
